// File: rtl/unidade_de_busca.sv
// Instruction fetch stage: program counter, next-PC selection,
// and retired/stall debug counters.
module unidade_de_busca #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  interrupt,
  input  logic [1:0]            pcSource,
  input  logic [15:0]           imm16,
  input  logic [25:0]           imm26,
  input  logic [DATA_WIDTH-1:0] regTarget,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pcPlusOne,
  output logic                  fetchValid,
  output logic                  stalled,
  output logic                  addrFault,
  output logic [CNT_WIDTH-1:0]  retiredCount,
  output logic [CNT_WIDTH-1:0]  stallCount
);

  localparam int TW = 64;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            advance;
  logic            hold;
  logic [TW-1:0]   tgt;
  logic            fault_hit;

  assign pcPlusOne  = pc + ADDR_WIDTH'(1);
  assign fetchValid = (state == RUN) || (state == STALL);
  assign stalled    = (state == STALL);

  // Targets widened so any bit above the PC width can be flagged.
  always_comb begin
    tgt = TW'(pcPlusOne);
    case (pcSource)
      2'b01:   tgt = TW'(imm16);
      2'b10:   tgt = TW'(regTarget);
      2'b11:   tgt = TW'(imm26);
      default: tgt = TW'(pcPlusOne);
    endcase
  end

  assign fault_hit = (pcSource != 2'b00) && (|(tgt >> ADDR_WIDTH));

  always_comb begin
    state_nxt = BOOT;
    advance   = 1'b0;
    hold      = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN, STALL: begin
        if (interrupt) begin
          hold      = 1'b1;
          state_nxt = STALL;
        end else begin
          advance   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= BOOT;
      pc           <= '0;
      addrFault    <= 1'b0;
      retiredCount <= '0;
      stallCount   <= '0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        pc           <= tgt[ADDR_WIDTH-1:0];
        retiredCount <= retiredCount + CNT_WIDTH'(1);
        if (fault_hit) addrFault <= 1'b1;
      end
      if (hold) stallCount <= stallCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_unidade_de_busca.sv
// Bench for unidade_de_busca: directed plan plus random stimulus
// against a behavioural reference model.
module tb_unidade_de_busca;

  logic        clock = 1'b0;
  logic        reset;
  logic        interrupt;
  logic [1:0]  pcSource;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] regTarget;
  logic [9:0]  pc;
  logic [9:0]  pcPlusOne;
  logic        fetchValid;
  logic        stalled;
  logic        addrFault;
  logic [31:0] retiredCount;
  logic [31:0] stallCount;

  int passed = 0;
  int total  = 0;

  unidade_de_busca #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(32),
    .CNT_WIDTH (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .interrupt   (interrupt),
    .pcSource    (pcSource),
    .imm16       (imm16),
    .imm26       (imm26),
    .regTarget   (regTarget),
    .pc          (pc),
    .pcPlusOne   (pcPlusOne),
    .fetchValid  (fetchValid),
    .stalled     (stalled),
    .addrFault   (addrFault),
    .retiredCount(retiredCount),
    .stallCount  (stallCount)
  );

  always #5 clock = ~clock;

  // Reference model: phase 0 = boot, 1 = running, 2 = held.
  int          m_phase;
  longint      m_pc;
  bit          m_fault;
  logic [31:0] m_ret;
  logic [31:0] m_stall;
  bit          m_live = 0;

  always @(posedge clock) begin
    longint t;
    if (reset) begin
      m_phase = 0;
      m_pc    = 0;
      m_fault = 0;
      m_ret   = 0;
      m_stall = 0;
      m_live  = 1;
    end else if (m_live) begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (interrupt) begin
        m_stall = m_stall + 1;
        m_phase = 2;
      end else begin
        if (pcSource == 0) begin
          m_pc = (m_pc + 1) % 1024;
        end else begin
          t = (pcSource == 1) ? longint'(imm16) :
              (pcSource == 2) ? longint'(regTarget) : longint'(imm26);
          if (t >= 1024) m_fault = 1;
          m_pc = t % 1024;
        end
        m_ret   = m_ret + 1;
        m_phase = 1;
      end
    end
  end

  task automatic check(input string name, input longint act,
                       input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h @%0t",
                  name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    if (m_live) begin
      check("m_pc", pc, m_pc);
      check("m_pc1", pcPlusOne, (m_pc + 1) % 1024);
      check("m_valid", fetchValid, m_phase != 0);
      check("m_stalled", stalled, m_phase == 2);
      check("m_fault", addrFault, m_fault);
      check("m_ret", retiredCount, m_ret);
      check("m_stall", stallCount, m_stall);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic go(input logic [1:0] src, input logic intr = 1'b0);
    pcSource  = src;
    interrupt = intr;
    tick();
  endtask

  task automatic jump(input logic [25:0] a);
    imm26 = a;
    go(2'b11);
  endtask

  initial begin
    reset = 1'b1; interrupt = 1'b0; pcSource = 2'b00;
    imm16 = '0; imm26 = '0; regTarget = '0;
    tick(2);
    check("rst_pc", pc, 0);
    check("rst_pc1", pcPlusOne, 1);
    check("rst_valid", fetchValid, 0);
    check("rst_stalled", stalled, 0);
    check("rst_ret", retiredCount, 0);

    reset = 1'b0;
    tick();
    check("boot_pc", pc, 0);
    check("boot_valid", fetchValid, 1);
    tick(4);
    check("seq_pc", pc, 4);
    check("seq_ret", retiredCount, 4);

    go(2'b00);
    check("pc5", pc, 5);
    jump(26'h200);
    check("j_pc", pc, 10'h200);
    check("j_pc1", pcPlusOne, 10'h201);
    check("j_fault", addrFault, 0);
    regTarget = 32'h0000_0F00;
    go(2'b10);
    check("jr_pc", pc, 10'h300);
    check("jr_fault", addrFault, 1);
    tick(3);
    check("sticky", addrFault, 1);

    jump(26'h010);
    imm16 = 16'h0040;
    go(2'b01);
    check("jf_pc", pc, 10'h040);
    jump(26'h3FF);
    go(2'b00);
    check("wrap_pc", pc, 10'h000);
    check("wrap_fault", addrFault, 1);

    jump(26'h020);
    imm26 = 26'h100;
    pcSource = 2'b11;
    interrupt = 1'b1;
    tick(4);
    check("hold_pc", pc, 10'h020);
    check("hold_stalled", stalled, 1);
    check("hold_cnt", stallCount, 4);
    go(2'b00);
    check("rel_pc", pc, 10'h021);
    check("rel_stalled", stalled, 0);

    jump(26'h030);
    interrupt = 1'b1;
    tick(2);
    reset = 1'b1;
    tick();
    check("rs_pc", pc, 0);
    check("rs_valid", fetchValid, 0);
    check("rs_stalled", stalled, 0);
    check("rs_fault", addrFault, 0);
    check("rs_stall", stallCount, 0);
    reset = 1'b0;
    go(2'b00);
    check("rs_boot_pc", pc, 0);
    go(2'b00);
    check("rs_adv_pc", pc, 1);

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      interrupt = ($urandom_range(0, 9) < 3);
      pcSource  = 2'($urandom_range(0, 3));
      imm16     = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                              : 16'($urandom_range(0, 1023));
      imm26     = ($urandom_range(0, 3) == 0) ? 26'($urandom)
                                              : 26'($urandom_range(0, 1023));
      regTarget = ($urandom_range(0, 3) == 0) ? $urandom
                                              : 32'($urandom_range(0, 1023));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
